lcd_bus_writer: RTL and testbench

- Parametrised 8080-style parallel write engine for the LCD panel.
- Drives the panel pins: dcx (command/data select), wr (write strobe) and D (data bus).
- Upstream image/command logic pushes {dcx, data} words through a valid/ready stream into an internal FIFO.
- Generalises the fixed 8-bit, fixed-timing writer to configurable bus width, FIFO depth and strobe timing, and adds back-pressure plus an idle flag.

---
 rtl/lcd_bus_pkg.sv | 29 ++
 rtl/lcd_wr_fifo.sv | 61 ++++++
 rtl/lcd_bus_writer.sv | 174 +++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared types and constants for the 8080-style LCD write path.
//   lcd_wr_state_t  - write FSM states
//   LCD_CMD/LCD_DATA - values for the D/CX line
//   LCD_CASET/RASET/RAMWR - common panel command codes
//   lcd_max()       - constant-expression helper for counter sizing
package lcd_bus_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETUP     = 2'd1,
        STROBE_LO = 2'd2,
        STROBE_HI = 2'd3
    } lcd_wr_state_t;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    localparam logic [7:0] LCD_CASET = 8'h2A;
    localparam logic [7:0] LCD_RASET = 8'h2B;
    localparam logic [7:0] LCD_RAMWR = 8'h2C;

    // Width of the per-word repeat count used by solid-colour fills.
    localparam int LCD_REP_W = 16;

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_wr_fifo.sv
// lcd_wr_fifo: synchronous FIFO with first-word fall-through read port.
//   hwclk, rst   - clock, synchronous active-high reset (clears pointers/count)
//   push, wdata  - write side; push ignored when full
//   pop, rdata   - read side; rdata is the current head, pop ignored when empty
//   full, empty  - occupancy flags
//   count        - current occupancy, 0..DEPTH
module lcd_wr_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     hwclk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge hwclk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: 8080-style parallel write engine for the LCD panel.
// Upstream pushes {dcx, data} words over valid/ready into a FIFO; the FSM
// pops each word onto dcx/D, gives one cycle of address setup, pulls wr low
// for WR_LO cycles and holds it high WR_HI cycles (panel latches on the
// rising edge). Back-to-back words take 1+WR_LO+WR_HI cycles each.
//
// Ports:
//   hwclk     - system clock, rising edge
//   rst       - synchronous active-high reset; aborts any transfer
//   in_valid  - upstream word valid
//   in_ready  - FIFO can accept (never asserted while full or in reset)
//   in_dcx    - 0 = command, 1 = data/parameter
//   in_data   - word to write
//   in_rep    - (LCD_BURST_FILL_EN only) extra repeats of this word
//   dcx, wr, D - panel D/CX, WRX (active low), data bus
//   idle      - FIFO empty and FSM in IDLE (registered)
//
// Build option: define LCD_BURST_FILL_EN to store a 16-bit repeat count
// with each word; the word is strobed in_rep+1 times without re-setup.
module lcd_bus_writer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_LO      = 1,
    parameter int WR_HI      = 1
) (
    input  logic              hwclk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_dcx,
    input  logic [DATA_W-1:0] in_data,
`ifdef LCD_BURST_FILL_EN
    input  logic [15:0]       in_rep,
`endif
    output logic              dcx,
    output logic              wr,
    output logic [DATA_W-1:0] D,
    output logic              idle
);

    import lcd_bus_pkg::*;

    localparam int CW  = $clog2(lcd_max(WR_LO, WR_HI)) + 1;
    localparam int CNW = $clog2(FIFO_DEPTH) + 1;
`ifdef LCD_BURST_FILL_EN
    localparam int FW  = LCD_REP_W + 1 + DATA_W;
`else
    localparam int FW  = 1 + DATA_W;
`endif

    localparam logic [CW-1:0] LO_LD = CW'(WR_LO - 1);
    localparam logic [CW-1:0] HI_LD = CW'(WR_HI - 1);

    lcd_wr_state_t    state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             push, pop;
    logic             f_full, f_empty;
    logic [CNW-1:0]   f_count;
    logic [FW-1:0]    f_wdata, f_rdata;
    logic             empty_nxt;

`ifdef LCD_BURST_FILL_EN
    logic [LCD_REP_W-1:0] rep_cnt, rep_nxt;
    assign f_wdata = {in_rep, in_dcx, in_data};
`else
    assign f_wdata = {in_dcx, in_data};
`endif

    // No pass-through when full: ready depends only on registered occupancy.
    assign in_ready = ~f_full & ~rst;
    assign push     = in_valid & in_ready;

    lcd_wr_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .hwclk (hwclk),
        .rst   (rst),
        .push  (push),
        .wdata (f_wdata),
        .pop   (pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    // Occupancy after this edge, so idle can be registered without a lag.
    assign empty_nxt = ((f_count == '0) && !push) ||
                       ((f_count == CNW'(1)) && pop && !push);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
`ifdef LCD_BURST_FILL_EN
        rep_nxt   = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (!f_empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = STROBE_LO;
                cnt_nxt   = LO_LD;
            end
            STROBE_LO: begin
                if (cnt == '0) begin
                    state_nxt = STROBE_HI;
                    cnt_nxt   = HI_LD;
                end else begin
                    cnt_nxt   = cnt - 1'b1;
                end
            end
            STROBE_HI: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
`ifdef LCD_BURST_FILL_EN
                    // Repeat the held word: dcx/D already settled, skip SETUP.
                    if (rep_cnt != '0) begin
                        rep_nxt   = rep_cnt - 1'b1;
                        state_nxt = STROBE_LO;
                        cnt_nxt   = LO_LD;
                    end else
`endif
                    if (!f_empty) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef LCD_BURST_FILL_EN
        if (pop)
            rep_nxt = f_rdata[FW-1 -: LCD_REP_W];
`endif
    end

    // wr is registered from the next state so the pin never glitches on
    // state decode; dcx/D move only on a pop and are held otherwise.
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wr    <= 1'b1;
            dcx   <= 1'b1;
            D     <= '0;
            idle  <= 1'b1;
`ifdef LCD_BURST_FILL_EN
            rep_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wr    <= (state_nxt != STROBE_LO);
            idle  <= (state_nxt == IDLE) && empty_nxt;
            if (pop) begin
                dcx <= f_rdata[DATA_W];
                D   <= f_rdata[DATA_W-1:0];
            end
`ifdef LCD_BURST_FILL_EN
            rep_cnt <= rep_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: two writer instances (8-bit 1/1 timing and 16-bit 3/2
// timing) share one stimulus stream. A per-instance reference model keeps
// the FIFO as a queue and derives panel pin values from each word's pop
// time with plain arithmetic; every cycle all outputs are compared.
module tb_lcd_bus_writer;
    import lcd_bus_pkg::*;

    localparam int DEPTH = 4;
    localparam int LO0 = 1, HI0 = 1, LO1 = 3, HI1 = 2;

    typedef struct packed {
        logic [15:0] rep;
        logic        dcx;
        logic [15:0] data;
    } word_t;

    logic        tb_clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_dcx = 1'b0;
    logic [15:0] in_data = '0;
`ifdef LCD_BURST_FILL_EN
    logic [15:0] in_rep = '0;
`endif
    logic        rdy0, dcx0, wr0, idle0;
    logic [7:0]  d0;
    logic        rdy1, dcx1, wr1, idle1;
    logic [15:0] d1;

    always #5 tb_clk = ~tb_clk;

    lcd_bus_writer #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .WR_LO(LO0), .WR_HI(HI0)) u_dut0 (
        .hwclk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_dcx(in_dcx), .in_data(in_data[7:0]),
`ifdef LCD_BURST_FILL_EN
        .in_rep(in_rep),
`endif
        .dcx(dcx0), .wr(wr0), .D(d0), .idle(idle0));

    lcd_bus_writer #(.DATA_W(16), .FIFO_DEPTH(DEPTH), .WR_LO(LO1), .WR_HI(HI1)) u_dut1 (
        .hwclk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_dcx(in_dcx), .in_data(in_data),
`ifdef LCD_BURST_FILL_EN
        .in_rep(in_rep),
`endif
        .dcx(dcx1), .wr(wr1), .D(d1), .idle(idle1));

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    word_t fq0[$];
    word_t fq1[$];
    word_t cur[2];
    int    last_pop[2];
    int    lo[2];
    int    hi[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? fq0.size() : fq1.size();
    endfunction

    // Cycles from a word's pop to the edge where the next pop may happen.
    function automatic int span(input int i);
        return 1 + (int'(cur[i].rep) + 1) * (lo[i] + hi[i]);
    endfunction

    function automatic bit exp_wr(input int i);
        int o, per;
        per = lo[i] + hi[i];
        o   = cyc - last_pop[i] - 1;
        return !(o >= 0 && o < (int'(cur[i].rep) + 1) * per && (o % per) < lo[i]);
    endfunction

    function automatic bit exp_idle(input int i);
        return qsize(i) == 0 && cyc >= last_pop[i] + span(i);
    endfunction

    task automatic model_edge(input int i, input bit r, input bit p, input word_t w);
        if (r) begin
            if (i == 0) fq0.delete(); else fq1.delete();
            cur[i]      = '{rep: 16'd0, dcx: 1'b1, data: 16'd0};
            last_pop[i] = -100000;
        end else begin
            if (qsize(i) > 0 && cyc >= last_pop[i] + span(i)) begin
                cur[i]      = (i == 0) ? fq0.pop_front() : fq1.pop_front();
                last_pop[i] = cyc;
            end
            if (p) begin
                if (i == 0) fq0.push_back(w); else fq1.push_back(w);
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance the
    // model at the rising edge, then compare every output at the next fall.
    task automatic step(input bit v, input bit dc, input logic [15:0] dat,
                        input logic [15:0] rp, input bit r);
        bit          p0, p1;
        logic [15:0] wrep;
        word_t       w0, w1;
        rst      = r;
        in_valid = v;
        in_dcx   = dc;
        in_data  = dat;
`ifdef LCD_BURST_FILL_EN
        in_rep   = rp;
        wrep     = rp;
`else
        wrep     = (rp == 16'd0) ? rp : 16'd0;
`endif
        p0 = v && !r && (fq0.size() < DEPTH);
        p1 = v && !r && (fq1.size() < DEPTH);
        w0 = '{rep: wrep, dcx: dc, data: {8'h00, dat[7:0]}};
        w1 = '{rep: wrep, dcx: dc, data: dat};
        @(posedge tb_clk);
        cyc++;
        model_edge(0, r, p0, w0);
        model_edge(1, r, p1, w1);
        @(negedge tb_clk);
        chk("rdy0",  rdy0,  !r && fq0.size() < DEPTH);
        chk("wr0",   wr0,   exp_wr(0));
        chk("dcx0",  dcx0,  cur[0].dcx);
        chk("d0",    d0,    cur[0].data[7:0]);
        chk("idle0", idle0, exp_idle(0));
        chk("rdy1",  rdy1,  !r && fq1.size() < DEPTH);
        chk("wr1",   wr1,   exp_wr(1));
        chk("dcx1",  dcx1,  cur[1].dcx);
        chk("d1",    d1,    cur[1].data);
        chk("idle1", idle1, exp_idle(1));
    endtask

    initial begin
        bit found;
        lo[0] = LO0; hi[0] = HI0; lo[1] = LO1; hi[1] = HI1;
        for (int i = 0; i < 2; i++) begin
            cur[i]      = '{rep: 16'd0, dcx: 1'b1, data: 16'd0};
            last_pop[i] = -100000;
        end

        // Reset for two cycles, then release.
        step(0, 0, 16'h0, 16'd0, 1);
        step(0, 0, 16'h0, 16'd0, 1);
        step(0, 0, 16'h0, 16'd0, 0);

        // Single command, then let both instances finish.
        step(1, LCD_CMD, {8'h00, LCD_RAMWR}, 16'd0, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 16'h0, 16'd0, 0);

        // Six words back to back against a depth-4 FIFO.
        for (int n = 0; n < 6; n++) step(1, LCD_DATA, 16'hA0 + 16'(n), 16'd0, 0);
        for (int n = 0; n < 40; n++) step(0, 0, 16'h0, 16'd0, 0);

        // Wide colour word.
        step(1, LCD_DATA, 16'hF800, 16'd0, 0);
        for (int n = 0; n < 10; n++) step(0, 0, 16'h0, 16'd0, 0);

        // Reset while the 8-bit instance has wr low.
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (!exp_wr(0)) found = 1'b1;
            else step(1, LCD_DATA, 16'h5A5A, 16'd0, 0);
        end
        chk("mid_rst_reached", found, 1'b1);
        step(0, 0, 16'h0, 16'd0, 1);
        for (int n = 0; n < 12; n++) step(0, 0, 16'h0, 16'd0, 0);

`ifdef LCD_BURST_FILL_EN
        // Solid fill: one word, five strobes.
        step(1, LCD_DATA, 16'h00FF, 16'd4, 0);
        for (int n = 0; n < 40; n++) step(0, 0, 16'h0, 16'd0, 0);
`endif

        // Random traffic with occasional resets.
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 99) < 60, 1'($urandom), 16'($urandom),
                 16'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
        end

        // Drain; bounded.
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            step(0, 0, 16'h0, 16'd0, 0);
            if (exp_idle(0) && exp_idle(1)) found = 1'b1;
        end
        chk("drain", found, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
